// File: rtl/sc_ipreg_bank.sv
// sc_ipreg_pkg / sc_ipreg_bank
//
// Reusable register bank: NREG 32-bit registers, each described by one
// sc_reg_param entry (per-bit masks for valid/write/wset/wclr/ronly/cnst plus
// init value and word address). Serves a req/ack bus port, merges hardware
// set events, supports read-to-clear bits, and produces a registered IRQ.
//
// Ports:
//   clk, rstn            clock (rising edge), async active-low reset
//   req, we, addr,       bus request; held stable by the master until ack
//   wstrb, wdata
//   ack, rdata, decerr   one-cycle registered response
//   hwset                per-bit hardware set, NREG*32, level-sampled
//   hwval                live value returned for read-only bits, NREG*32
//   regout               stored register values (cnst bits forced), NREG*32
//   wpulse               one-cycle pulse per written register
//   irq                  registered interrupt

package sc_ipreg_pkg;
    typedef struct packed {
        logic [31:0] addr;   // byte address; decoded on [AW-1:2]
        logic [31:0] valid;  // implemented bits
        logic [31:0] init;   // reset / constant value
        logic [31:0] write;  // plain read/write bits
        logic [31:0] wset;   // write-1-to-set bits
        logic [31:0] wclr;   // write-1-to-clear bits
        logic [31:0] ronly;  // read-only bits, value comes from hwval
        logic [31:0] cnst;   // constant bits, always init
    } sc_reg_param;
endpackage

module sc_ipreg_bank #(
    parameter int unsigned                     NREG    = 4,
    parameter int unsigned                     AW      = 16,
    parameter sc_ipreg_pkg::sc_reg_param [NREG-1:0] RP = '0,
    parameter logic [NREG-1:0][31:0]           RCLR    = '0,
    parameter int unsigned                     ISR_IDX = 0,
    parameter int unsigned                     IER_IDX = 0,
    parameter bit                              IRQ_EN  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [3:0]           wstrb,
    input  logic [31:0]          wdata,
    output logic                 ack,
    output logic [31:0]          rdata,
    output logic                 decerr,
    input  logic [NREG*32-1:0]   hwset,
    input  logic [NREG*32-1:0]   hwval,
    output logic [NREG*32-1:0]   regout,
    output logic [NREG-1:0]      wpulse,
    output logic                 irq
);

    localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

    // Bits that actually hold state: implemented, not read-only, not constant.
    function automatic logic [NREG-1:0][31:0] calc_settable();
        logic [NREG-1:0][31:0] m;
        for (int i = 0; i < NREG; i++)
            m[i] = RP[i].valid & ~RP[i].ronly & ~RP[i].cnst;
        return m;
    endfunction

    function automatic logic [NREG-1:0][31:0] calc_rstval();
        logic [NREG-1:0][31:0] m;
        for (int i = 0; i < NREG; i++)
            m[i] = RP[i].valid & ~RP[i].ronly & RP[i].init;
        return m;
    endfunction

    localparam logic [NREG-1:0][31:0] SETTABLE = calc_settable();
    localparam logic [NREG-1:0][31:0] RSTVAL   = calc_rstval();

    logic                  accept;
    logic                  hit_any;
    logic [IW-1:0]         hit_idx;
    logic [31:0]           bmask;
    logic [31:0]           rd_hit;
    logic [NREG-1:0]       wp_nxt;
    logic [NREG-1:0][31:0] q, q_nxt;
    logic [NREG-1:0][31:0] hs_v, hv_v, ro_v;

    assign hs_v   = hwset;
    assign hv_v   = hwval;
    assign regout = ro_v;

    // REQ is ignored while ACK is high, so a held request yields one access
    // every two cycles.
    assign accept = req & ~ack;
    assign bmask  = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};

    // Address decode; scanning downwards lets the lowest matching index win.
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment so no latch is inferred.
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (RP[i].valid != '0 && addr[AW-1:2] == RP[i].addr[AW-1:2]) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Next state, read data and write pulses.
    always_comb begin
        q_nxt  = q;
        rd_hit = '0;
        wp_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            // Default: hardware events set bits, otherwise hold.
            q_nxt[i] = q[i] | hs_v[i];
            if (accept && hit_any && hit_idx == IW'(i)) begin
                if (we) begin
                    wp_nxt[i] = 1'b1;
                    // Plain write bits take wdata and override hwset.
                    q_nxt[i] = (q_nxt[i] & ~(RP[i].write & bmask))
                             | (wdata & RP[i].write & bmask);
                    q_nxt[i] = q_nxt[i] | (wdata & RP[i].wset & ~RP[i].write & bmask);
                    // A clear loses against a same-cycle hardware set.
                    q_nxt[i] = q_nxt[i] & ~(wdata & RP[i].wclr & ~RP[i].write
                                            & ~RP[i].wset & bmask & ~hs_v[i]);
                end else begin
                    rd_hit   = (RP[i].init & RP[i].cnst)
                             | (hv_v[i] & RP[i].ronly & RP[i].valid & ~RP[i].cnst)
                             | (q[i] & SETTABLE[i]);
                    q_nxt[i] = q_nxt[i] & ~(RCLR[i] & ~hs_v[i]);
                end
            end
            q_nxt[i] = (q_nxt[i] & SETTABLE[i]) | (RP[i].init & RP[i].cnst);
        end
    end

    always_comb begin
        ro_v = '0;
        for (int i = 0; i < NREG; i++)
            ro_v[i] = (q[i] & ~RP[i].cnst) | (RP[i].init & RP[i].cnst);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the register array is real control state visible on
            // regout, so it is reset like any flop rather than left as RAM.
            q      <= RSTVAL;
            ack    <= 1'b0;
            rdata  <= '0;
            decerr <= 1'b0;
            wpulse <= '0;
            irq    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            q      <= q_nxt;
            ack    <= accept;
            rdata  <= (accept && !we && hit_any) ? rd_hit : 32'h0;
            decerr <= accept & ~hit_any;
            wpulse <= wp_nxt;
            irq    <= IRQ_EN & (|(ro_v[ISR_IDX] & ro_v[IER_IDX]));
        end
    end

endmodule

// File: tb/tb_sc_ipreg_bank.sv
// Randomized self-checking bench for sc_ipreg_bank using the four-register
// test configuration (R0 rw, R1 ISR, R2 IER, R3 ronly/cnst) and a bit-level
// reference model applied per completed transaction.
module tb_sc_ipreg_bank;
    import sc_ipreg_pkg::*;

    function automatic sc_reg_param mk(input logic [31:0] a, v, i, w, s, c, r, k);
        sc_reg_param p;
        p.addr = a; p.valid = v; p.init = i; p.write = w;
        p.wset = s; p.wclr = c; p.ronly = r; p.cnst = k;
        return p;
    endfunction

    localparam sc_reg_param P0 = mk(32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 0, 0);
    localparam sc_reg_param P1 = mk(32'h4, 32'h0000_FFFF, 32'h0, 0, 0, 32'h0000_00FF, 0, 0);
    localparam sc_reg_param P2 = mk(32'h8, 32'h0000_00FF, 32'h0, 32'h0000_00FF, 0, 0, 0, 0);
    localparam sc_reg_param P3 = mk(32'hC, 32'hFFFF_FFFF, 32'hA5A5_0000, 0, 0, 0, 32'h0000_FFFF, 32'hFFFF_0000);
    localparam sc_reg_param [3:0] TB_RP = {P3, P2, P1, P0};
    localparam logic [3:0][31:0] TB_RCLR = {32'h0, 32'h0, 32'h0000_FF00, 32'h0};

    logic         clk = 1'b0, rstn = 1'b0;
    logic         req = 1'b0, we = 1'b0;
    logic [15:0]  addr = '0;
    logic [3:0]   wstrb = '0;
    logic [31:0]  wdata = '0;
    logic [127:0] hwset = '0, hwval = '0;
    logic         ack, decerr, irq;
    logic [31:0]  rdata;
    logic [127:0] regout;
    logic [3:0]   wpulse;

    int errors = 0;
    int checks = 0;
    logic [31:0] mq [4];   // model stored bits

    sc_ipreg_bank #(
        .NREG(4), .AW(16), .RP(TB_RP), .RCLR(TB_RCLR),
        .ISR_IDX(1), .IER_IDX(2), .IRQ_EN(1'b1)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wstrb(wstrb),
        .wdata(wdata), .ack(ack), .rdata(rdata), .decerr(decerr), .hwset(hwset),
        .hwval(hwval), .regout(regout), .wpulse(wpulse), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < 4; i++)
            mq[i] = TB_RP[i].valid & ~TB_RP[i].ronly & TB_RP[i].init;
    endfunction

    function automatic logic [31:0] model_regout(input int i);
        logic [31:0] r;
        for (int b = 0; b < 32; b++)
            r[b] = TB_RP[i].cnst[b] ? TB_RP[i].init[b] : mq[i][b];
        return r;
    endfunction

    function automatic logic model_irq();
        return |(model_regout(1) & model_regout(2));
    endfunction

    function automatic int model_hit(input logic [15:0] a);
        for (int i = 0; i < 4; i++)
            if (TB_RP[i].valid != 0 && a[15:2] == TB_RP[i].addr[15:2]) return i;
        return -1;
    endfunction

    // One bus event (or none, when hit<0 and acc=0) plus hardware sets,
    // walking the priority list bit by bit.
    function automatic void model_step(input bit acc, input bit w, input int hit,
                                       input logic [3:0] st, input logic [31:0] wd,
                                       input logic [127:0] hs);
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 32; b++) begin
                logic cur, hb, nb;
                cur = mq[i][b];
                hb  = hs[i*32 + b];
                if (TB_RP[i].cnst[b])                          nb = TB_RP[i].init[b];
                else if (!TB_RP[i].valid[b] || TB_RP[i].ronly[b]) nb = 1'b0;
                else if (acc && w && hit == i && st[b/8]) begin
                    if (TB_RP[i].write[b])      nb = wd[b];
                    else if (TB_RP[i].wset[b])  nb = cur | wd[b] | hb;
                    else if (TB_RP[i].wclr[b])  nb = wd[b] ? hb : (cur | hb);
                    else                        nb = cur | hb;
                end else if (acc && !w && hit == i && TB_RCLR[i][b]) nb = hb;
                else                                           nb = cur | hb;
                mq[i][b] = nb;
            end
        end
    endfunction

    function automatic logic [31:0] model_rdata(input int hit);
        logic [31:0] r = '0;
        for (int b = 0; b < 32; b++) begin
            if (TB_RP[hit].cnst[b])        r[b] = TB_RP[hit].init[b];
            else if (!TB_RP[hit].valid[b]) r[b] = 1'b0;
            else if (TB_RP[hit].ronly[b])  r[b] = hwval[hit*32 + b];
            else                           r[b] = mq[hit][b];
        end
        return r;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_regout%0d", tag, i), regout[i*32 +: 32], model_regout(i));
    endtask

    task automatic access(input bit w, input logic [15:0] a, input logic [3:0] st,
                          input logic [31:0] wd, input logic [127:0] hs,
                          output logic [31:0] got);
        int hit, lat;
        logic [31:0] erd;
        logic [3:0]  ewp;
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wstrb = st; wdata = wd; hwset = hs;
        hit = model_hit(a);
        erd = (!w && hit >= 0) ? model_rdata(hit) : 32'h0;
        ewp = (w && hit >= 0) ? (4'b1 << hit) : 4'b0;
        model_step(1'b1, w, hit, st, wd, hs);
        lat = 0;
        do begin
            @(posedge clk); #1;
            hwset = '0;
            lat++;
        end while (!ack && lat < 8);
        got = rdata;
        check("ack_latency", 32'(lat), 32'd1);
        check("rdata", rdata, erd);
        check("decerr", 32'(decerr), 32'(hit < 0));
        check("wpulse", 32'(wpulse), 32'(ewp));
        req = 1'b0;
        @(posedge clk); #1;
        check("ack_pulse", 32'(ack), 32'd0);
        check("wpulse_pulse", 32'(wpulse), 32'd0);
        check_regs("acc");
        check("irq", 32'(irq), 32'(model_irq()));
    endtask

    task automatic hw_pulse(input logic [127:0] hs);
        logic old_irq;
        @(posedge clk); #1;
        hwset = hs;
        old_irq = model_irq();
        @(posedge clk); #1;
        hwset = '0;
        model_step(1'b0, 1'b0, -1, 4'h0, 32'h0, hs);
        check_regs("hw");
        check("irq_lag", 32'(irq), 32'(old_irq));
        @(posedge clk); #1;
        check("irq_hw", 32'(irq), 32'(model_irq()));
    endtask

    logic [31:0] rd;
    logic [15:0] addr_tab [7] = '{16'h0, 16'h4, 16'h8, 16'hC, 16'h10, 16'h20, 16'h0};

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check_regs("rst");
        rstn = 1'b1;

        // Reset value readback and strobed write.
        access(1'b0, 16'h0, 4'h0, 32'h0, '0, rd);
        check("r0_init", rd, 32'h1234_5678);
        access(1'b1, 16'h0, 4'b0101, 32'hFFFF_FFFF, '0, rd);
        access(1'b0, 16'h0, 4'h0, 32'h0, '0, rd);
        check("r0_strobe", rd, 32'h12FF_56FF);
        access(1'b1, 16'h0, 4'b0000, 32'h0, '0, rd);   // wpulse with no strobes

        // Interrupt path: enable bit3, then hardware set ISR bit3.
        access(1'b1, 16'h8, 4'hF, 32'h08, '0, rd);
        hw_pulse(128'h8 << 32);
        check("irq_set", 32'(irq), 32'd1);
        access(1'b1, 16'h4, 4'hF, 32'h08, '0, rd);
        check("irq_fall", 32'(irq), 32'd0);
        // Clear collides with a hardware set: bit survives.
        access(1'b1, 16'h4, 4'hF, 32'h08, 128'h8 << 32, rd);
        check("wclr_vs_hwset", regout[32 +: 32] & 32'h8, 32'h8);
        access(1'b1, 16'h4, 4'hF, 32'h08, '0, rd);

        // Read-to-clear.
        hw_pulse(128'h200 << 32);
        access(1'b0, 16'h4, 4'h0, 32'h0, '0, rd);
        check("rclr_first", rd, 32'h200);
        access(1'b0, 16'h4, 4'h0, 32'h0, '0, rd);
        check("rclr_second", rd, 32'h0);

        // Read-only / constant register and decode error.
        hwval = 128'h0000_BEEF << 96;
        access(1'b1, 16'hC, 4'hF, 32'h0, '0, rd);
        access(1'b0, 16'hC, 4'h0, 32'h0, '0, rd);
        check("r3_read", rd, 32'hA5A5_BEEF);
        access(1'b0, 16'h20, 4'h0, 32'h0, '0, rd);
        check("decerr_rdata", rd, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            logic [15:0]  a;
            logic [127:0] hs;
            a  = addr_tab[$urandom_range(0, 6)];
            if (n % 7 == 6) a = 16'($urandom) & 16'hFFFC;
            hs = '0;
            if ($urandom_range(0, 2) == 0)
                hs = {$urandom, $urandom, $urandom, $urandom};
            hwval = {$urandom, $urandom, $urandom, $urandom};
            access(1'($urandom), a, 4'($urandom), $urandom, hs, rd);
            if ($urandom_range(0, 4) == 0)
                hw_pulse({$urandom, $urandom, $urandom, $urandom});
        end

        // Reset during the accept cycle drops the pending ack.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 16'h0; wstrb = 4'hF; wdata = 32'hDEAD_BEEF;
        #2 rstn = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_wpulse", 32'(wpulse), 32'd0);
        check_regs("rst_mid");
        req = 1'b0;
        rstn = 1'b1;
        access(1'b0, 16'h0, 4'h0, 32'h0, '0, rd);
        check("post_rst_r0", rd, 32'h1234_5678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sc_ipreg_bank.md
# sc_ipreg_bank

Parametrised register bank that replaces per-IP hand-instantiated register decode with one reusable block. It holds NREG 32-bit registers described by `sc_reg_param` entries from `sc_ipreg_pkg`, serves a simple req/ack bus port, and merges hardware events into status bits. Beyond the per-bit write/set/clear/read-only/constant access types, it adds:
- hardware set inputs,
- read-to-clear bits,
- per-register write strobes,
- a registered interrupt output.

It sits between the IP's bus slave adapter and its core logic.

## Interface
- NREG, 4: number of registers (1..64)
- AW, 16: address width; word-decoded on ADDR[AW-1:2]
- RP, all-zero: `sc_reg_param [NREG-1:0]`, per-register description
- RCLR, 0: `logic [NREG-1:0][31:0]`, bits cleared by an accepted read
- ISR_IDX, 0: index of the interrupt status register
- IER_IDX, 0: index of the interrupt enable register
- IRQ_EN, 0: 1 enables IRQ generation
- CLK  in  1  clock; all logic is on the rising edge
- RSTN  in  1  asynchronous, active-low reset
- REQ  in  1  access request
- WE  in  1  1 = write, 0 = read
- ADDR  in  AW  byte address
- WSTRB  in  4  byte write enables
- WDATA  in  32  write data
- ACK  out  1  access done, one-cycle pulse
- RDATA  out  32  read data, valid while ACK=1
- DECERR  out  1  no register matched; valid while ACK=1
- HWSET  in  NREG*32  per-bit hardware set, level-sampled each cycle
- HWVAL  in  NREG*32  live value for read-only bits
- REGOUT  out  NREG*32  stored register values
- WPULSE  out  NREG  one-cycle pulse per written register
- IRQ  out  1  registered interrupt

## Operation
Access acceptance and decode:
- An access is accepted in any cycle with REQ=1 and ACK=0.
- Address match: register i hits when ADDR[AW-1:2] == RP[i].addr[AW-1:2] and RP[i].valid != 0.
- If several registers hit, the lowest index wins.
- If none hits: no state change, RDATA=0, DECERR=1.

Per-bit next value, in priority order:
1. `cnst`: bit is init, always.
2. Not `valid`, or `ronly`: stored bit is 0.
3. Accepted write hitting this register, with WSTRB[b/8]=1:
   - `write` bit: takes WDATA[b]; bus write wins over HWSET.
   - `wset` bit: set if WDATA[b]=1.
   - `wclr` bit: cleared if WDATA[b]=1, unless HWSET[b]=1 the same cycle. The event is kept and the bit ends at 1.
4. Accepted read hitting this register, with the RCLR bit set: bit clears unless HWSET=1 the same cycle.
5. Otherwise HWSET=1 sets the bit (all non-cnst, non-ronly valid bits); else the bit holds.

Read data and outputs:
- RDATA bit for a hit register:
  - `cnst` bit: init.
  - `ronly` bit: HWVAL sampled in the accept cycle.
  - Other valid bits: stored value before any read-clear or write in that cycle.
  - Invalid bits: 0.
- A write returns RDATA=0.
- WPULSE[i]=1 in the ACK cycle of a write that hit register i, even if WSTRB=0.
- REGOUT shows stored values, with `cnst` bits forced to init.
- IRQ = IRQ_EN & |(REGOUT[ISR_IDX] & REGOUT[IER_IDX]), registered.

## Timing
Reset values:
- Stored bits: valid & ~ronly & init.
- ACK, RDATA, DECERR, WPULSE, IRQ all 0.

Handshake and latency:
- Register state updates at the edge ending the accept cycle.
- ACK, RDATA, DECERR and WPULSE are registered and asserted the following cycle, for exactly one cycle.
- REQ held high gives one access every 2 cycles. REQ is not sampled while ACK=1.
- Master must hold WE, ADDR, WSTRB and WDATA stable until ACK.

Other timing:
- HWSET effect appears on REGOUT 1 cycle later. IRQ lags REGOUT by 1 cycle.
- Reset asserted mid-access: the pending ACK is dropped and all state returns to reset values immediately.

## Test plan
Test config (NREG=4):
- R0: @0x0, write all bits, init 0x12345678.
- R1: @0x4, ISR, wclr [7:0], RCLR[1]=0x0000FF00 on [15:8], HWSET-driven.
- R2: @0x8, IER, write [7:0].
- R3: @0xC, ronly [15:0], cnst [31:16] init 0xA5A5.
- IRQ_EN=1, ISR_IDX=1, IER_IDX=2.

Scenarios:
- Reset, read 0x0 -> RDATA=0x12345678, ACK exactly 1 cycle after the accept cycle, DECERR=0.
- Write 0x0 WDATA=0xFFFFFFFF WSTRB=0b0101 -> read returns 0x12FF56FF; WPULSE[0]=1 for one cycle, aligned with ACK.
- HWSET R1 bit3; write R2=0x08 -> IRQ=1 two cycles after the set. Write R1=0x08 -> IRQ falls.
- Write R1=0x08 with HWSET bit3 in the accept cycle -> R1 bit3 stays 1.
- HWSET R1 bit9, read 0x4 -> RDATA=0x200; next read returns 0x0.
- HWVAL R3=0x0000BEEF, write 0xC=0, read 0xC -> 0xA5A5BEEF. Read 0x20 -> RDATA=0, DECERR=1.
